// File: rtl/int_controller.sv
// rtl/int_controller.sv - fixed-priority interrupt controller for a single int_req/int_ack core pair
module int_controller #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               int_req,
  input  logic               int_ack,
  input  logic               int_done,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] sync1, sync2, hist;
  logic [NUM_SRC-1:0] mask, edge_mode, pending;
  logic [NUM_SRC-1:0] rise, eligible, wr_clr, ack_clr;
  logic [ID_W-1:0]    winner;
  logic               take_ack;
  logic [7:0]         rd_mux;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise     = sync2 & ~hist;
  assign eligible = pending & mask;
  assign take_ack = (state == REQ) && int_ack;
  assign wr_clr   = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[NUM_SRC-1:0] : '0;

  // Lowest set index wins; scanning downward leaves the smallest index last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take_ack && eligible[i] && winner == ID_W'(i)) ack_clr[i] = 1'b1;
    end
  end

  // A new rising edge beats any clear in the same cycle; level bits just track the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (edge_mode & (rise | (pending & ~(wr_clr | ack_clr))))
               | (~edge_mode & sync2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask      <= '0;
      edge_mode <= '1;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    mask      <= cfg_wdata[NUM_SRC-1:0];
        2'd1:    edge_mode <= cfg_wdata[NUM_SRC-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= winner;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
            int_id     <= winner;
          end else if (~|eligible) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else begin
            int_id <= winner;
          end
        end
        SERVICE: begin
          if (int_done) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      2'd0: rd_mux[NUM_SRC-1:0] = mask;
      2'd1: rd_mux[NUM_SRC-1:0] = edge_mode;
      2'd2: rd_mux[NUM_SRC-1:0] = pending;
      default: begin
        rd_mux[ID_W-1:0] = int_id;
        rd_mux[6]        = int_req;
        rd_mux[7]        = in_service;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cfg_rdata <= '0;
    else          cfg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - scoreboard bench for int_controller
module tb_int_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] irq_in = '0;
  logic       int_req;
  logic       int_ack = 1'b0;
  logic       int_done = 1'b0;
  logic [2:0] int_id;
  logic       in_service;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rd_q[$];
  logic [2:0] id_q[$];

  int_controller #(.NUM_SRC(4), .ID_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in),
    .int_req(int_req), .int_ack(int_ack), .int_done(int_done),
    .int_id(int_id), .in_service(in_service),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] e;
    rd_q.push_back(exp);
    cfg_addr = a;
    step();
    e = rd_q.pop_front();
    check(tag, cfg_rdata, e);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 12 && !int_req; i++) step();
    check(tag, int_req, 1);
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq_in = lines;
    step(3);
    irq_in = '0;
  endtask

  task automatic do_ack(input string tag);
    logic [2:0] e;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check({tag, "_req"}, int_req, 0);
    check({tag, "_svc"}, in_service, 1);
    if (id_q.size() == 0) begin
      check({tag, "_idq"}, 0, 1);
    end else begin
      e = id_q.pop_front();
      check({tag, "_id"}, int_id, e);
    end
  endtask

  task automatic do_done(input string tag);
    int_done = 1'b1;
    step();
    int_done = 1'b0;
    check(tag, in_service, 0);
  endtask

  initial begin
    step(2);
    check("rst_req", int_req, 0);
    check("rst_id", int_id, 0);
    check("rst_svc", in_service, 0);
    check("rst_rdata", cfg_rdata, 0);
    reset_n = 1'b1;
    cfg_read("rst_mask", 2'd0, 8'h00);
    cfg_read("rst_edge", 2'd1, 8'h0F);
    cfg_read("rst_pend", 2'd2, 8'h00);

    // basic edge interrupt with exact latency
    cfg_write(2'd0, 8'h01);
    irq_in = 4'b0001;
    id_q.push_back(3'd0);
    step(3);
    irq_in = '0;
    check("basic_early", int_req, 0);
    step();
    check("basic_req", int_req, 1);
    do_ack("basic_ack");
    cfg_read("basic_pend", 2'd2, 8'h00);
    do_done("basic_done");
    step(5);
    check("basic_norereq", int_req, 0);

    // priority: 1 before 3
    cfg_write(2'd0, 8'h0F);
    id_q.push_back(3'd1);
    id_q.push_back(3'd3);
    pulse(4'b1010);
    wait_req("prio_req1");
    do_ack("prio_ack1");
    do_done("prio_done1");
    wait_req("prio_req3");
    do_ack("prio_ack3");
    do_done("prio_done3");

    // mask withdraw
    pulse(4'b0100);
    wait_req("mask_req");
    cfg_write(2'd0, 8'h00);
    check("mask_hold", int_req, 1);
    step();
    check("mask_drop", int_req, 0);
    cfg_read("mask_pend", 2'd2, 8'h04);
    cfg_write(2'd0, 8'h04);
    id_q.push_back(3'd2);
    wait_req("mask_rereq");
    do_ack("mask_ack");
    do_done("mask_done");

    // level mode
    cfg_write(2'd1, 8'h00);
    cfg_write(2'd0, 8'h01);
    irq_in = 4'b0001;
    id_q.push_back(3'd0);
    wait_req("lvl_req");
    do_ack("lvl_ack");
    do_done("lvl_done");
    wait_req("lvl_rereq");
    irq_in = '0;
    for (int i = 0; i < 8 && int_req; i++) step();
    check("lvl_withdraw", int_req, 0);
    check("lvl_idle", in_service, 0);
    cfg_read("lvl_pend", 2'd2, 8'h00);
    cfg_write(2'd1, 8'h0F);

    // nesting blocked, clear races
    cfg_write(2'd0, 8'h03);
    id_q.push_back(3'd0);
    pulse(4'b0001);
    wait_req("nest_req");
    do_ack("nest_ack");
    pulse(4'b0010);
    step(3);
    check("nest_noreq", int_req, 0);
    check("nest_svc", in_service, 1);
    cfg_read("nest_pend", 2'd2, 8'h02);
    cfg_write(2'd2, 8'h02);
    cfg_read("nest_clr", 2'd2, 8'h00);
    irq_in = 4'b0010;
    step(2);
    cfg_write(2'd2, 8'h02);
    irq_in = '0;
    cfg_read("race_setwins", 2'd2, 8'h02);
    do_done("nest_done");
    id_q.push_back(3'd1);
    wait_req("race_req");
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h02;
    do_ack("race_ack");
    cfg_we = 1'b0;
    cfg_read("race_ackpend", 2'd2, 8'h00);
    do_done("race_done");

    // reset mid-service
    cfg_write(2'd0, 8'h07);
    id_q.push_back(3'd0);
    pulse(4'b0001);
    wait_req("rst2_req");
    do_ack("rst2_ack");
    pulse(4'b0110);
    step();
    cfg_read("rst2_pend", 2'd2, 8'h06);
    cfg_read("rst2_status", 2'd3, 8'h80);
    reset_n = 1'b0;
    #1;
    check("rst2_req0", int_req, 0);
    check("rst2_svc0", in_service, 0);
    check("rst2_id0", int_id, 0);
    check("rst2_rdata0", cfg_rdata, 0);
    step();
    reset_n = 1'b1;
    cfg_read("rst2_mask", 2'd0, 8'h00);
    cfg_read("rst2_edge", 2'd1, 8'h0F);
    cfg_read("rst2_pendz", 2'd2, 8'h00);
    cfg_read("rst2_stat", 2'd3, 8'h00);

    check("idq_empty", id_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
